stk_pipe_al: RTL and testbench
==============================

# stk_pipe_al

Line allocator for the stack pipeline. Holds a free list of line pointers in a circular buffer, initialises it after reset, and hands out one pointer per allocation request. Sits beside the AD stage, which drives `i_alloc` for every outgoing PUSH and gates dequeue on `o_empty_r`/`o_busy_r`. Lines released by downstream POP completion are returned through the free port.

## Interface
- `LINES_N`, default 16 — number of allocatable lines; power of two, ≥2.
- `PTR_W`, default `$clog2(LINES_N)` — line pointer width.

- `clk` input 1 — clock.
- `arst` input 1 — asynchronous, active-high reset.
- `i_alloc` input 1 — allocate one line this cycle.
- `o_alloc_vld_r` output 1 — `o_alloc_ptr_r` is a newly allocated line (one-cycle pulse).
- `o_alloc_ptr_r` output PTR_W — allocated line pointer.
- `i_free` input 1 — return one line this cycle.
- `i_free_ptr` input PTR_W — pointer being returned.
- `o_empty_r` output 1 — free list holds no lines.
- `o_busy_r` output 1 — initialisation in progress; no allocation permitted.
- `o_count_r` output PTR_W+1 — number of free lines.
- `o_err_r` output 2 — sticky error flags:
  - [0] underflow: alloc while empty or busy.
  - [1] overflow: free while full or busy.

## Operation
- **Storage**
  - LINES_N×PTR_W register file.
  - Read pointer `rd` and write pointer `wr`, PTR_W bits each; both wrap modulo LINES_N.
  - Count is PTR_W+1 bits.
- **States**
  - INIT: entered on reset.
  - RUN: entered after the last INIT write; never left except by reset.
- **INIT**
  - Counter k starts at 0; each cycle writes entry[k] = k.
  - The edge that writes k = LINES_N−1 moves to RUN and sets count = LINES_N, `rd` = 0, `wr` = 0, `o_empty_r` = 0, `o_busy_r` = 0.
  - `i_alloc` in INIT: ignored, sets err[0].
  - `i_free` in INIT: ignored, sets err[1].
- **Alloc in RUN with count > 0**
  - `o_alloc_ptr_r` <= entry[rd]; `o_alloc_vld_r` <= 1; rd++; count−−.
- **Free in RUN with count < LINES_N**
  - entry[wr] <= `i_free_ptr`; wr++; count++.
- **Simultaneous alloc and free, 0 < count < LINES_N**
  - Both performed; count unchanged.
  - The alloc reads the pre-edge entry[rd]; the freed pointer is never returned the same cycle.
- **Alloc with count == 0**
  - Behaviour depends on Configuration (see below).
- **Free with count == LINES_N and no simultaneous alloc**
  - Free is dropped; err[1] set.
  - A simultaneous alloc at full is legal: alloc and free both performed, count stays LINES_N.
- **Flags**
  - `o_empty_r` = (next count == 0), registered with count.
  - err bits are sticky until reset.
- No pointer uniqueness checking is performed; duplicate frees are the caller's responsibility.

## Timing
- **Reset values:** `o_alloc_vld_r` 0, `o_alloc_ptr_r` 0, `o_empty_r` 1, `o_busy_r` 1, `o_count_r` 0, `o_err_r` 0; state INIT, k = 0.
- **Initialisation:** exactly LINES_N rising edges after reset deassertion. `o_busy_r`/`o_empty_r` fall and `o_count_r` = LINES_N after the LINES_N-th edge.
- **Alloc latency:** 1 cycle. `i_alloc` at cycle t gives `o_alloc_vld_r`/`o_alloc_ptr_r` at t+1.
- **Back-to-back allocs:** one per cycle, yielding consecutive entries.
- **Free-to-reuse:** a line freed at t is visible to an alloc at t+1 when count was 0. `o_empty_r` falls at t+1.
- **Alloc that takes the last line:** `o_empty_r` rises at the following edge. The AD stage samples `o_empty_r`, so it never issues at t+1 on stale data.
- **Reset mid-operation:** asserting `arst` at any time restarts INIT from k = 0 and discards all pointers.

## Configuration
- **`STK_AL_BYPASS_EN` defined:** alloc and free in the same RUN cycle with count == 0 forward `i_free_ptr` directly to `o_alloc_ptr_r`, with `o_alloc_vld_r` = 1. No write is made, count stays 0, `o_empty_r` stays 1, no error.
- **Not defined:** in that case the alloc is ignored, `o_alloc_vld_r` = 0 and err[0] is set. The free is performed normally: count becomes 1, `o_empty_r` = 0.
- **Either way:** alloc with count == 0 and no free sets err[0] and produces no `o_alloc_vld_r`.

## Test plan
All scenarios use LINES_N = 4.
- **Reset and init:** release `arst` -> `o_busy_r` = 1 for 4 edges, then `o_busy_r` = 0, `o_empty_r` = 0, `o_count_r` = 4, `o_err_r` = 0.
- **Drain:** 4 back-to-back allocs after init -> `o_alloc_ptr_r` 0, 1, 2, 3 on consecutive cycles; `o_empty_r` = 1 after the 4th; `o_count_r` = 0.
- **Refill in order:** after drain, free 2 then free 0, then 2 allocs -> ptrs 2, 0; count path 1, 2, 1, 0.
- **Underflow:** alloc at count 0 with no free -> `o_alloc_vld_r` = 0, `o_err_r` = 2'b01. Alloc during INIT -> same flag; INIT still completes with count 4.
- **Simultaneous at full:** alloc+free at count 4 with `i_free_ptr` = 3 -> ptr 0, count 4, no error. Free alone at count 4 -> `o_err_r` = 2'b10.
- **Bypass:** at count 0, alloc+free with ptr 1:
  - with `STK_AL_BYPASS_EN` -> `o_alloc_ptr_r` = 1, vld 1, count 0, no error.
  - without it -> vld 0, err[0] = 1, count 1.
- **Reset mid-INIT:** assert `arst` at init cycle 2 -> outputs return to reset values; a full 4-cycle INIT follows.

Source files
------------

// File: rtl/stk_pipe_al.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stk_pipe_al : stack-pipeline line allocator. Circular free list of line  |
// | pointers, self-initialised after reset, one alloc and one free per cycle.|
// | Optional macro STK_AL_BYPASS_EN forwards a free straight to an alloc     |
// | when the list is empty.                                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stk_pipe_al #(
  parameter int LINES_N = 16,
  parameter int PTR_W   = $clog2(LINES_N)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_alloc,
  output logic             o_alloc_vld_r,
  output logic [PTR_W-1:0] o_alloc_ptr_r,
  input  logic             i_free,
  input  logic [PTR_W-1:0] i_free_ptr,
  output logic             o_empty_r,
  output logic             o_busy_r,
  output logic [PTR_W:0]   o_count_r,
  output logic [1:0]       o_err_r
);

  localparam logic [PTR_W:0]   c_FULL_CNT = (PTR_W+1)'(LINES_N);
  localparam logic [PTR_W-1:0] c_LAST_K   = PTR_W'(LINES_N - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_k;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_mem [LINES_N];

  logic             w_init_done;
  logic             w_cnt_zero;
  logic             w_cnt_full;
  logic             w_bypass;
  logic             w_alloc_ok;
  logic             w_free_ok;
  logic             w_underflow;
  logic             w_overflow;
  logic [PTR_W:0]   w_count_nxt;

  assign w_init_done = (r_k == c_LAST_K);
  assign w_cnt_zero  = (o_count_r == '0);
  assign w_cnt_full  = (o_count_r == c_FULL_CNT);

`ifdef STK_AL_BYPASS_EN
  // Empty list with a concurrent free: hand the freed line straight back.
  assign w_bypass = i_alloc & i_free & w_cnt_zero;
`else
  assign w_bypass = 1'b0;
`endif

  // A free at full is only legal when an alloc vacates a slot the same cycle.
  assign w_alloc_ok  = i_alloc & ~w_cnt_zero;
  assign w_free_ok   = i_free & ~w_bypass & (~w_cnt_full | i_alloc);
  assign w_underflow = i_alloc & w_cnt_zero & ~w_bypass;
  assign w_overflow  = i_free & w_cnt_full & ~i_alloc;
  assign w_count_nxt = o_count_r
                     + {{PTR_W{1'b0}}, w_free_ok}
                     - {{PTR_W{1'b0}}, w_alloc_ok};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_init_done) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Free-list storage; contents are rebuilt by INIT, so no reset is needed.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_k] <= r_k;
    end else if (w_free_ok) begin
      r_mem[r_wr] <= i_free_ptr;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_k           <= '0;
      r_rd          <= '0;
      r_wr          <= '0;
      o_alloc_vld_r <= 1'b0;
      o_alloc_ptr_r <= '0;
      o_empty_r     <= 1'b1;
      o_busy_r      <= 1'b1;
      o_count_r     <= '0;
      o_err_r       <= 2'b00;
    end else begin
      o_alloc_vld_r <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_k <= r_k + 1'b1;
          if (i_alloc) o_err_r[0] <= 1'b1;
          if (i_free)  o_err_r[1] <= 1'b1;
          if (w_init_done) begin
            o_count_r <= c_FULL_CNT;
            r_rd      <= '0;
            r_wr      <= '0;
            o_empty_r <= 1'b0;
            o_busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_bypass) begin
            o_alloc_vld_r <= 1'b1;
            o_alloc_ptr_r <= i_free_ptr;
          end else if (w_alloc_ok) begin
            o_alloc_vld_r <= 1'b1;
            o_alloc_ptr_r <= r_mem[r_rd];
            r_rd          <= r_rd + 1'b1;
          end
          if (w_free_ok) r_wr <= r_wr + 1'b1;
          o_count_r <= w_count_nxt;
          o_empty_r <= (w_count_nxt == '0);
          if (w_underflow) o_err_r[0] <= 1'b1;
          if (w_overflow)  o_err_r[1] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stk_pipe_al.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stk_pipe_al : directed self-checking bench for stk_pipe_al, LINES_N=4.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_stk_pipe_al;

  localparam int LINES_N = 4;
  localparam int PTR_W   = 2;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             i_alloc = 1'b0;
  logic             i_free = 1'b0;
  logic [PTR_W-1:0] i_free_ptr = '0;
  logic             o_alloc_vld_r;
  logic [PTR_W-1:0] o_alloc_ptr_r;
  logic             o_empty_r;
  logic             o_busy_r;
  logic [PTR_W:0]   o_count_r;
  logic [1:0]       o_err_r;

  int n_vec = 0;
  int n_bad = 0;

  stk_pipe_al #(.LINES_N(LINES_N), .PTR_W(PTR_W)) u_dut (
    .clk           (clk),
    .arst          (arst),
    .i_alloc       (i_alloc),
    .o_alloc_vld_r (o_alloc_vld_r),
    .o_alloc_ptr_r (o_alloc_ptr_r),
    .i_free        (i_free),
    .i_free_ptr    (i_free_ptr),
    .o_empty_r     (o_empty_r),
    .o_busy_r      (o_busy_r),
    .o_count_r     (o_count_r),
    .o_err_r       (o_err_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic tick(input logic a, input logic f, input logic [PTR_W-1:0] p);
    i_alloc    = a;
    i_free     = f;
    i_free_ptr = p;
    @(posedge clk);
    #1;
    i_alloc = 1'b0;
    i_free  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"},   32'(o_alloc_vld_r), 32'd0);
    chk({tag, "_ptr"},   32'(o_alloc_ptr_r), 32'd0);
    chk({tag, "_empty"}, 32'(o_empty_r),     32'd1);
    chk({tag, "_busy"},  32'(o_busy_r),      32'd1);
    chk({tag, "_count"}, 32'(o_count_r),     32'd0);
    chk({tag, "_err"},   32'(o_err_r),       32'd0);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("rst");
    arst = 1'b0;
  endtask

  // Runs INIT to completion, optionally driving alloc on the first INIT edge.
  task automatic run_init(input logic alloc_first, input logic [1:0] err_exp);
    for (int i = 0; i < LINES_N - 1; i++) begin
      tick(alloc_first && i == 0, 1'b0, '0);
      chk("init_busy", 32'(o_busy_r), 32'd1);
    end
    tick(1'b0, 1'b0, '0);
    chk("init_done_busy",  32'(o_busy_r),  32'd0);
    chk("init_done_empty", 32'(o_empty_r), 32'd0);
    chk("init_done_count", 32'(o_count_r), 32'd4);
    chk("init_done_err",   32'(o_err_r),   32'(err_exp));
  endtask

  initial begin
    // Reset and init
    @(posedge clk);
    #1;
    do_reset();
    run_init(1'b0, 2'b00);

    // Drain: pointers 0..3 in order
    for (int i = 0; i < LINES_N; i++) begin
      tick(1'b1, 1'b0, '0);
      chk("drain_vld",   32'(o_alloc_vld_r), 32'd1);
      chk("drain_ptr",   32'(o_alloc_ptr_r), 32'(i));
      chk("drain_count", 32'(o_count_r),     32'(LINES_N - 1 - i));
    end
    chk("drain_empty", 32'(o_empty_r), 32'd1);
    tick(1'b0, 1'b0, '0);
    chk("idle_vld", 32'(o_alloc_vld_r), 32'd0);

    // Refill with 2 then 0, allocate them back
    tick(1'b0, 1'b1, 2'd2);
    chk("refill_c1",     32'(o_count_r), 32'd1);
    chk("refill_empty",  32'(o_empty_r), 32'd0);
    tick(1'b0, 1'b1, 2'd0);
    chk("refill_c2",     32'(o_count_r), 32'd2);
    tick(1'b1, 1'b0, '0);
    chk("refill_ptr_a",  32'(o_alloc_ptr_r), 32'd2);
    chk("refill_c3",     32'(o_count_r),     32'd1);
    tick(1'b1, 1'b0, '0);
    chk("refill_ptr_b",  32'(o_alloc_ptr_r), 32'd0);
    chk("refill_c4",     32'(o_count_r),     32'd0);
    chk("refill_empty2", 32'(o_empty_r),     32'd1);

    // Underflow at count 0
    tick(1'b1, 1'b0, '0);
    chk("uflow_vld",   32'(o_alloc_vld_r), 32'd0);
    chk("uflow_err",   32'(o_err_r),       32'd1);
    chk("uflow_count", 32'(o_count_r),     32'd0);

    // Alloc + free at count 0
    tick(1'b1, 1'b1, 2'd1);
`ifdef STK_AL_BYPASS_EN
    chk("byp_vld",   32'(o_alloc_vld_r), 32'd1);
    chk("byp_ptr",   32'(o_alloc_ptr_r), 32'd1);
    chk("byp_count", 32'(o_count_r),     32'd0);
    chk("byp_empty", 32'(o_empty_r),     32'd1);
    chk("byp_err",   32'(o_err_r),       32'd1);
`else
    chk("nobyp_vld",   32'(o_alloc_vld_r), 32'd0);
    chk("nobyp_count", 32'(o_count_r),     32'd1);
    chk("nobyp_empty", 32'(o_empty_r),     32'd0);
    chk("nobyp_err",   32'(o_err_r),       32'd1);
    tick(1'b1, 1'b0, '0);
    chk("nobyp_reuse_vld", 32'(o_alloc_vld_r), 32'd1);
    chk("nobyp_reuse_ptr", 32'(o_alloc_ptr_r), 32'd1);
    chk("nobyp_reuse_cnt", 32'(o_count_r),     32'd0);
`endif

    // Alloc during INIT flags underflow, INIT still completes
    do_reset();
    run_init(1'b1, 2'b01);

    // Simultaneous alloc+free at full, then free alone at full
    do_reset();
    run_init(1'b0, 2'b00);
    tick(1'b1, 1'b1, 2'd3);
    chk("full_sim_vld",   32'(o_alloc_vld_r), 32'd1);
    chk("full_sim_ptr",   32'(o_alloc_ptr_r), 32'd0);
    chk("full_sim_count", 32'(o_count_r),     32'd4);
    chk("full_sim_err",   32'(o_err_r),       32'd0);
    tick(1'b0, 1'b1, 2'd1);
    chk("oflow_err",   32'(o_err_r),   32'd2);
    chk("oflow_count", 32'(o_count_r), 32'd4);
    // Freed 3 landed at slot 0; order continues 1,2,3,3
    for (int i = 0; i < LINES_N; i++) begin
      tick(1'b1, 1'b0, '0);
      chk("wrap_ptr", 32'(o_alloc_ptr_r), (i == LINES_N - 1) ? 32'd3 : 32'(i + 1));
    end

    // Reset mid-INIT
    do_reset();
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    arst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    arst = 1'b0;
    run_init(1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end

endmodule
`default_nettype wire
